// File: rtl/booth_radix8_seq.sv
// Sequential radix-8 Booth multiplier: retires three multiplier bits per clock
// using a precomputed 3*MC hard multiple, with a signed/unsigned mode per operation.
module booth_radix8_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int EXT = 3 * ((WIDTH + 3) / 3);
    localparam int N   = EXT / 3;
    localparam int AW  = WIDTH + 4;
    localparam int CW  = $clog2(N + 1);
    localparam int FW  = AW + EXT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [WIDTH:0]     mce_r;
    logic [AW-1:0]      m3_r;
    logic [AW-1:0]      acc_r;
    logic [EXT-1:0]     mpr_r;
    logic               t_r;
    logic [CW-1:0]      cnt_r;

    logic [AW-1:0]      m1_s;
    logic [AW-1:0]      pp_s;
    logic [AW-1:0]      sum_s;
    logic [FW:0]        cat_s;
    logic [FW:0]        shr_s;
    logic               mp_fill_s;

    // Partial product for one Booth digit; negation stays in AW bits so -4*MC is exact.
    function automatic logic [AW-1:0] booth_pp(input logic [3:0] dig,
                                               input logic [AW-1:0] m1,
                                               input logic [AW-1:0] m3);
        logic [AW-1:0] m2;
        logic [AW-1:0] m4;
        m2 = {m1[AW-2:0], 1'b0};
        m4 = {m1[AW-3:0], 2'b00};
        case (dig)
            4'b0000, 4'b1111: booth_pp = '0;
            4'b0001, 4'b0010: booth_pp = m1;
            4'b0011, 4'b0100: booth_pp = m2;
            4'b0101, 4'b0110: booth_pp = m3;
            4'b0111:          booth_pp = m4;
            4'b1000:          booth_pp = ~m4 + {{(AW-1){1'b0}}, 1'b1};
            4'b1001, 4'b1010: booth_pp = ~m3 + {{(AW-1){1'b0}}, 1'b1};
            4'b1011, 4'b1100: booth_pp = ~m2 + {{(AW-1){1'b0}}, 1'b1};
            4'b1101, 4'b1110: booth_pp = ~m1 + {{(AW-1){1'b0}}, 1'b1};
            default:          booth_pp = '0;
        endcase
    endfunction

    // Datapath for one iteration: add the selected multiple, then arithmetic shift by 3.
    always_comb begin
        m1_s      = {{(AW-WIDTH-1){mce_r[WIDTH]}}, mce_r};
        pp_s      = booth_pp({mpr_r[2:0], t_r}, m1_s, m3_r);
        sum_s     = acc_r + pp_s;
        cat_s     = {sum_s, mpr_r, t_r};
        shr_s     = $signed(cat_s) >>> 3;
        mp_fill_s = signed_mode & mp[WIDTH-1];
    end

    // Control FSM and all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            mce_r   <= '0;
            m3_r    <= '0;
            acc_r   <= '0;
            mpr_r   <= '0;
            t_r     <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            prod    <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mce_r   <= signed_mode ? {mc[WIDTH-1], mc} : {1'b0, mc};
                        mpr_r   <= {{(EXT-WIDTH){mp_fill_s}}, mp};
                        t_r     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= S_PRE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_PRE: begin
                    m3_r    <= m1_s + {m1_s[AW-2:0], 1'b0};
                    acc_r   <= '0;
                    cnt_r   <= '0;
                    state_r <= S_ITER;
                end
                S_ITER: begin
                    acc_r <= shr_s[FW:EXT+1];
                    mpr_r <= shr_s[EXT:1];
                    t_r   <= shr_s[0];
                    cnt_r <= cnt_r + CW'(1);
                    // The final product is captured on the same edge that enters S_DONE,
                    // so prod is already valid while done is high.
                    if (cnt_r == CW'(N - 1)) begin
                        prod    <= shr_s[2*WIDTH:1];
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_ITER;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix8_seq.sv
// Self-checking bench for booth_radix8_seq (WIDTH=16): directed corners, handshake,
// mid-operation reset, and random operands against a plain-arithmetic model.
module tb_booth_radix8_seq;

    localparam int W   = 16;
    localparam int NIT = (W + 3) / 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic           busy;
    logic           done;
    logic [2*W-1:0] prod;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    booth_radix8_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .mc(mc), .mp(mp), .busy(busy), .done(done), .prod(prod)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint x;
        longint y;
        logic [63:0] p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = 64'(x * y);
        return p[2*W-1:0];
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int edges;
        logic [2*W-1:0] held;
        wait_idle();
        start = 1'b1; signed_mode = s; mc = a; mp = b;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            start = 1'b0;
            signed_mode = ~s; mc = ~a; mp = ~b;
        end while (!done && edges < 40);
        check_val({tag, "_latency"}, 64'(edges), 64'(NIT + 2));
        check_val({tag, "_prod"}, 64'(prod), 64'(exp));
        check_val({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        held = prod;
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_val({tag, "_prod_hold"}, 64'(prod), 64'(held));
    endtask

    initial begin
        logic [2*W-1:0] first_exp;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;
        int             d0;
        int             guard;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; mc = '0; mp = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_prod", 64'(prod), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Directed corner cases with hand-computed products.
        run_op("s_min_min",   1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        run_op("u_max_max",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_op("s_m1_m1",     1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
        run_op("s_m1_p1",     1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF);
        run_op("s_1234_neg",  1'b1, 16'd1234, 16'hFB2E, 32'hFFE8_C3BC);
        run_op("u_zero",      1'b0, 16'h0000, 16'hBEEF, 32'h0000_0000);
        run_op("u_min_min",   1'b0, 16'h8000, 16'h8000, 32'h4000_0000);
        run_op("s_min_max",   1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000);

        // Restart requests while busy and during DONE must all be ignored.
        wait_idle();
        ra = 16'd3000; rb = 16'd7;
        first_exp = 32'd21000;
        d0 = done_cnt;
        start = 1'b1; signed_mode = 1'b0; mc = ra; mp = rb;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
            mc = 16'($urandom); mp = 16'($urandom); signed_mode = 1'($urandom);
        end while (!done && guard < 40);
        check_val("busy_start_prod", 64'(prod), 64'(first_exp));
        @(posedge clk); #1;
        check_val("start_in_done_ignored", 64'(busy), 64'd0);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("busy_start_one_done", 64'(done_cnt - d0), 64'd1);
        check_val("busy_start_prod_hold", 64'(prod), 64'(first_exp));

        // Synchronous reset while iterating at digit count 3.
        wait_idle();
        start = 1'b1; signed_mode = 1'b1; mc = 16'h1234; mp = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        check_val("midreset_busy", 64'(busy), 64'd0);
        check_val("midreset_done", 64'(done), 64'd0);
        check_val("midreset_prod", 64'(prod), 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("midreset_idle", 64'(busy), 64'd0);
        run_op("after_reset", 1'b1, 16'h1234, 16'h5678, ref_mul(1'b1, 16'h1234, 16'h5678));

        // Random operands in both modes, with occasional extreme values.
        for (int i = 0; i < 1200; i++) begin
            rs = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
            run_op("random", rs, ra, rb, ref_mul(rs, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
